frame_seq_ctrl: RTL

- Top-level sequencer for the photo-frame image buffer. It drives the buffer's 8-bit `state` bus through three states: WAIT=8'h01, RECEIVE=8'h02, DISPLAY=8'h03.
- Inputs that move it between states: UART command bytes, the buffer's completion flags, and the VGA frame-start pulse.
- It adds a receive-stall timeout, vsync-aligned switch to display, and a status/error interface for LEDs.

---
 rtl/frame_seq_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/frame_seq_ctrl.sv
// Frame sequencer for the photo-frame image buffer: WAIT -> RECEIVE -> DISPLAY,
// with a receive-stall timeout and a vsync-aligned handover to display.
//
// state | meaning
// 8'h01 | WAIT    : idle, buffer clears its flags, waiting for 'S'
// 8'h02 | RECEIVE : pixels arriving; stall timer running until image complete
// 8'h03 | DISPLAY : complete image shown, held until a new command
module frame_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  parameter int unsigned PIX_TOTAL   = 2000,
  parameter logic [7:0]  CMD_START   = 8'h53,
  parameter logic [7:0]  CMD_CLEAR   = 8'h43
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_byte,
  input  logic [14:0] pix_cnt,
  input  logic        image_complete,
  input  logic        image_receiving,
  input  logic        vsync_pulse,
  output logic [7:0]  state,
  output logic        disp_pending,
  output logic        err_timeout,
  output logic        img_valid,
  output logic [25:0] stall_cnt
);

  localparam logic [7:0]  ST_WAIT     = 8'h01;
  localparam logic [7:0]  ST_RECV     = 8'h02;
  localparam logic [7:0]  ST_DISP     = 8'h03;
  localparam logic [25:0] STALL_LIMIT = 26'(TIMEOUT_CYC - 1);

  logic [14:0] last_cnt;
  logic        is_start;
  logic        is_clear;
  logic        progress;
  logic        timeout_hit;

  // Pixel total and receiving flag are owned by the buffer; kept here for interface parity.
  logic unused_inputs;
  assign unused_inputs = ^{image_receiving, 15'(PIX_TOTAL)};

  assign is_start    = cmd_valid && (cmd_byte == CMD_START);
  assign is_clear    = cmd_valid && (cmd_byte == CMD_CLEAR);
  assign progress    = (pix_cnt != last_cnt);
  assign timeout_hit = !image_complete && !progress && (stall_cnt == STALL_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_WAIT;
      disp_pending <= 1'b0;
      err_timeout  <= 1'b0;
      img_valid    <= 1'b0;
      stall_cnt    <= '0;
      last_cnt     <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (is_start) begin
            state        <= ST_RECV;
            err_timeout  <= 1'b0;
            img_valid    <= 1'b0;
            disp_pending <= 1'b0;
            stall_cnt    <= '0;
            last_cnt     <= '0;
          end
        end
        ST_RECV: begin
          last_cnt <= pix_cnt;
          if (is_clear) begin
            state        <= ST_WAIT;
            disp_pending <= 1'b0;
          end else if (timeout_hit) begin
            state       <= ST_WAIT;
            err_timeout <= 1'b1;
          end else if (image_complete || disp_pending) begin
            // Complete image: stop stall tracking and hand over on the next frame start.
            stall_cnt <= '0;
            if (vsync_pulse) begin
              state        <= ST_DISP;
              disp_pending <= 1'b0;
              img_valid    <= 1'b1;
            end else begin
              disp_pending <= 1'b1;
            end
          end else if (progress) begin
            stall_cnt <= '0;
          end else if (stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 26'd1;
          end
        end
        ST_DISP: begin
          if (is_clear) begin
            state     <= ST_WAIT;
            img_valid <= 1'b0;
          end else if (is_start) begin
            state     <= ST_RECV;
            img_valid <= 1'b0;
            stall_cnt <= '0;
            last_cnt  <= '0;
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule
